// File: rtl/vga_pkg.sv
// Shared VGA timing defaults, pattern mode encodings and a width helper.
package vga_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;
  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  typedef enum logic [1:0] {
    MODE_OFF    = 2'd0,
    MODE_BARS   = 2'd1,
    MODE_CHECK  = 2'd2,
    MODE_SCROLL = 2'd3
  } vga_mode_e;

  // Bits needed to hold 0..value-1; never less than one bit.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned w = value - 1; w > 0; w = w >> 1) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/vga_sync_counter.sv
// Pixel clock divider, horizontal/vertical position counters and sync decode.
module vga_sync_counter
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter int unsigned CLK_DIV  = 2,
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW      = clog2(H_TOTAL),
  localparam int unsigned VW      = clog2(V_TOTAL)
) (
  input  logic          clk,
  input  logic          reset,
  output logic          pix_tick_c,
  output logic [HW-1:0] h_cnt,
  output logic [VW-1:0] v_cnt,
  output logic          hsync_c,
  output logic          vsync_c,
  output logic          active_c,
  output logic          origin_c
);

  localparam int unsigned DIV_W = clog2(CLK_DIV);

  logic [DIV_W-1:0] div;

  assign pix_tick_c = (div == DIV_W'(CLK_DIV - 1));

  // Divider: counts clk cycles within one pixel period.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          div <= '0;
    else if (pix_tick_c) div <= '0;
    else                 div <= div + DIV_W'(1);
  end

  // Position of the next pixel to be presented; advances once per pixel.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (pix_tick_c) begin
      if (h_cnt == HW'(H_TOTAL - 1)) begin
        h_cnt <= '0;
        v_cnt <= (v_cnt == VW'(V_TOTAL - 1)) ? '0 : v_cnt + VW'(1);
      end else begin
        h_cnt <= h_cnt + HW'(1);
      end
    end
  end

  // Raw (active-high) sync, visible-area and frame-origin decode of the position.
  always_comb begin
    hsync_c  = (h_cnt >= HW'(H_ACTIVE + H_FP)) && (h_cnt <= HW'(H_ACTIVE + H_FP + H_SYNC - 1));
    vsync_c  = (v_cnt >= VW'(V_ACTIVE + V_FP)) && (v_cnt <= VW'(V_ACTIVE + V_FP + V_SYNC - 1));
    active_c = (h_cnt < HW'(H_ACTIVE)) && (v_cnt < VW'(V_ACTIVE));
    origin_c = (h_cnt == '0) && (v_cnt == '0);
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator with test patterns (off, colour bars, checkerboard, scroll).
// Optional VGA_BORDER_EN: draw a white one-pixel frame around the visible area.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE   = H_ACTIVE_DEF,
  parameter int unsigned H_FP       = H_FP_DEF,
  parameter int unsigned H_SYNC     = H_SYNC_DEF,
  parameter int unsigned H_BP       = H_BP_DEF,
  parameter int unsigned V_ACTIVE   = V_ACTIVE_DEF,
  parameter int unsigned V_FP       = V_FP_DEF,
  parameter int unsigned V_SYNC     = V_SYNC_DEF,
  parameter int unsigned V_BP       = V_BP_DEF,
  parameter int unsigned COLOR_BITS = 4,
  parameter int unsigned CLK_DIV    = 2,
  parameter bit          SYNC_POL   = 1'b0,
  parameter int unsigned CHECK_LOG2 = 5,
  localparam int unsigned H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP,
  localparam int unsigned V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP,
  localparam int unsigned HW        = clog2(H_TOTAL),
  localparam int unsigned VW        = clog2(V_TOTAL)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [1:0]            mode,
  output logic [COLOR_BITS-1:0] red,
  output logic [COLOR_BITS-1:0] green,
  output logic [COLOR_BITS-1:0] blue,
  output logic                  hsync,
  output logic                  vsync,
  output logic [HW-1:0]         hcount,
  output logic [VW-1:0]         vcount,
  output logic                  active,
  output logic                  frame_start
);

  logic                  pix_tick_c, hsync_c, vsync_c, active_c, origin_c, start_c;
  logic [HW-1:0]         h_cnt;
  logic [VW-1:0]         v_cnt;
  vga_mode_e             mode_q, mode_eff_c;
  logic [7:0]            frame_cnt, fcnt_eff_c;
  logic [2:0]            bar_c;
  logic [COLOR_BITS-1:0] red_c, green_c, blue_c;

  vga_sync_counter #(
    .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
    .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
    .CLK_DIV  (CLK_DIV)
  ) u_sync (
    .clk        (clk),
    .reset      (reset),
    .pix_tick_c (pix_tick_c),
    .h_cnt      (h_cnt),
    .v_cnt      (v_cnt),
    .hsync_c    (hsync_c),
    .vsync_c    (vsync_c),
    .active_c   (active_c),
    .origin_c   (origin_c)
  );

  assign start_c = pix_tick_c && origin_c;

  // Pattern colour for the pixel about to be presented; the frame's first pixel
  // already uses the freshly sampled mode and frame count.
  always_comb begin
    mode_eff_c = start_c ? vga_mode_e'(mode) : mode_q;
    fcnt_eff_c = start_c ? frame_cnt + 8'd1 : frame_cnt;
    bar_c      = 3'((32'(h_cnt) * 32'd8) / H_ACTIVE);
    red_c      = '0;
    green_c    = '0;
    blue_c     = '0;
    if (active_c) begin
      case (mode_eff_c)
        MODE_BARS: begin
          red_c   = {COLOR_BITS{bar_c[2]}};
          green_c = {COLOR_BITS{bar_c[1]}};
          blue_c  = {COLOR_BITS{bar_c[0]}};
        end
        MODE_CHECK: begin
          red_c   = {COLOR_BITS{h_cnt[CHECK_LOG2] ^ v_cnt[CHECK_LOG2]}};
          green_c = red_c;
          blue_c  = red_c;
        end
        MODE_SCROLL: begin
          red_c   = COLOR_BITS'(32'(h_cnt) + 32'(fcnt_eff_c));
          green_c = COLOR_BITS'(v_cnt);
          blue_c  = fcnt_eff_c[7 -: COLOR_BITS];
        end
        default: ;
      endcase
`ifdef VGA_BORDER_EN
      if ((h_cnt == '0) || (h_cnt == HW'(H_ACTIVE - 1)) ||
          (v_cnt == '0) || (v_cnt == VW'(V_ACTIVE - 1))) begin
        red_c   = '1;
        green_c = '1;
        blue_c  = '1;
      end
`endif
    end
  end

  // Output registers: one pixel's colour, sync, active and position move together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      hsync       <= ~SYNC_POL;
      vsync       <= ~SYNC_POL;
      hcount      <= '0;
      vcount      <= '0;
      active      <= 1'b0;
      frame_start <= 1'b0;
      mode_q      <= MODE_OFF;
      frame_cnt   <= '0;
    end else begin
      frame_start <= start_c;
      if (pix_tick_c) begin
        red    <= red_c;
        green  <= green_c;
        blue   <= blue_c;
        hsync  <= hsync_c ? SYNC_POL : ~SYNC_POL;
        vsync  <= vsync_c ? SYNC_POL : ~SYNC_POL;
        hcount <= h_cnt;
        vcount <= v_cnt;
        active <= active_c;
      end
      if (start_c) begin
        mode_q    <= mode_eff_c;
        frame_cnt <= fcnt_eff_c;
      end
    end
  end

endmodule
